pipelined_decode_stage: RTL

//  Registered, back-pressured successor to the combinational control unit. Decodes one MIPS word per

---
 rtl/cpu_types_pkg.sv | 62 ++++++
 rtl/pipelined_decode_stage_ctrl_decoder.sv | 107 ++++++++++
 rtl/pipelined_decode_stage.sv | 109 ++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared decode types: control-word layout, field encodings and MIPS-I opcode/funct values.
package cpu_types_pkg;

    typedef enum logic [3:0] {
        ALU_SLL, ALU_SRL, ALU_ADD, ALU_SUB, ALU_AND,
        ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU
    } aluop_t;

    localparam logic [1:0] REGDST_RT     = 2'd0;
    localparam logic [1:0] REGDST_RD     = 2'd1;
    localparam logic [1:0] REGDST_R31    = 2'd2;
    localparam logic [1:0] MEMTOREG_ALU  = 2'd0;
    localparam logic [1:0] MEMTOREG_MEM  = 2'd1;
    localparam logic [1:0] MEMTOREG_PC4  = 2'd2;
    localparam logic [1:0] MEMTOREG_LUI  = 2'd3;
    localparam logic [1:0] ALUSRC_RT     = 2'd0;
    localparam logic [1:0] ALUSRC_IMM    = 2'd1;
    localparam logic [1:0] ALUSRC_SHAMT  = 2'd2;
    localparam logic [1:0] JUMPSEL_SEQ   = 2'd0;
    localparam logic [1:0] JUMPSEL_J25   = 2'd1;
    localparam logic [1:0] JUMPSEL_RS    = 2'd2;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J     = 6'h02, OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE   = 6'h05, OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09, OP_SLTI  = 6'h0a, OP_SLTIU = 6'h0b;
    localparam logic [5:0] OP_ANDI  = 6'h0c, OP_ORI   = 6'h0d, OP_XORI  = 6'h0e;
    localparam logic [5:0] OP_LUI   = 6'h0f, OP_LW    = 6'h23, OP_SW    = 6'h2b;
    localparam logic [5:0] OP_LL    = 6'h30, OP_SC    = 6'h38, OP_HALT  = 6'h3f;

    localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20, FN_ADDU = 6'h21, FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23, FN_AND  = 6'h24, FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26, FN_NOR  = 6'h27, FN_SLT  = 6'h2a;
    localparam logic [5:0] FN_SLTU = 6'h2b;

    typedef struct packed {
        aluop_t      alu_op;
        logic [1:0]  ALUsrc;
        logic [1:0]  RegDst;
        logic [1:0]  JumpSel;
        logic [1:0]  MemToReg;
        logic        RegWr;
        logic        dWEN;
        logic        dREN;
        logic        PCsrc;
        logic        BNE;
        logic        ExtOp;
        logic        datomic;
        logic        halt;
        logic        is_jump;
        logic        illegal;
        logic [4:0]  Rs;
        logic [4:0]  Rt;
        logic [4:0]  Rd;
        logic [4:0]  shamt;
        logic [15:0] imm16;
        logic [25:0] j25;
    } ctrl_word_t;

    localparam int CTRL_W = $bits(ctrl_word_t);

endpackage

// File: rtl/pipelined_decode_stage_ctrl_decoder.sv
// Combinational MIPS-I decoder: one instruction word in, one packed control word out.
module ctrl_decoder
    import cpu_types_pkg::*;
#(
    parameter int ATOMIC_EN = 1
) (
    input  logic [31:0]       imemload,
    output logic [CTRL_W-1:0] ctrl
);

    ctrl_word_t w;

    always_comb begin
        w        = '0;
        w.alu_op = ALU_ADD;
        w.Rs     = imemload[25:21];
        w.Rt     = imemload[20:16];
        w.Rd     = imemload[15:11];
        w.shamt  = imemload[10:6];
        w.imm16  = imemload[15:0];
        w.j25    = imemload[25:0];
        case (imemload[31:26])
            OP_RTYPE: begin
                w.RegDst = REGDST_RD;
                w.RegWr  = 1'b1;
                case (imemload[5:0])
                    FN_SLL:           begin w.alu_op = ALU_SLL; w.ALUsrc = ALUSRC_SHAMT; end
                    FN_SRL:           begin w.alu_op = ALU_SRL; w.ALUsrc = ALUSRC_SHAMT; end
                    FN_JR:            begin w.RegWr = 1'b0; w.JumpSel = JUMPSEL_RS; w.is_jump = 1'b1; end
                    FN_ADD, FN_ADDU:  w.alu_op = ALU_ADD;
                    FN_SUB, FN_SUBU:  w.alu_op = ALU_SUB;
                    FN_AND:           w.alu_op = ALU_AND;
                    FN_OR:            w.alu_op = ALU_OR;
                    FN_XOR:           w.alu_op = ALU_XOR;
                    FN_NOR:           w.alu_op = ALU_NOR;
                    FN_SLT:           w.alu_op = ALU_SLT;
                    FN_SLTU:          w.alu_op = ALU_SLTU;
                    default:          w.illegal = 1'b1;
                endcase
            end
            OP_J:   begin w.JumpSel = JUMPSEL_J25; w.is_jump = 1'b1; end
            OP_JAL: begin
                w.JumpSel  = JUMPSEL_J25;
                w.is_jump  = 1'b1;
                w.RegWr    = 1'b1;
                w.RegDst   = REGDST_R31;
                w.MemToReg = MEMTOREG_PC4;
            end
            OP_BEQ, OP_BNE: begin
                w.alu_op = ALU_SUB;
                w.PCsrc  = 1'b1;
                w.ExtOp  = 1'b1;
                w.BNE    = (imemload[31:26] == OP_BNE);
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
                w.RegWr  = 1'b1;
                w.ALUsrc = ALUSRC_IMM;
                w.ExtOp  = 1'b1;
                if (imemload[31:26] == OP_SLTI)  w.alu_op = ALU_SLT;
                if (imemload[31:26] == OP_SLTIU) w.alu_op = ALU_SLTU;
            end
            OP_ANDI: begin w.RegWr = 1'b1; w.ALUsrc = ALUSRC_IMM; w.alu_op = ALU_AND; end
            OP_ORI:  begin w.RegWr = 1'b1; w.ALUsrc = ALUSRC_IMM; w.alu_op = ALU_OR;  end
            OP_XORI: begin w.RegWr = 1'b1; w.ALUsrc = ALUSRC_IMM; w.alu_op = ALU_XOR; end
            OP_LUI:  begin w.RegWr = 1'b1; w.MemToReg = MEMTOREG_LUI; end
            OP_LW, OP_LL: begin
                w.RegWr    = 1'b1;
                w.dREN     = 1'b1;
                w.MemToReg = MEMTOREG_MEM;
                w.ALUsrc   = ALUSRC_IMM;
                w.ExtOp    = 1'b1;
                w.datomic  = (imemload[31:26] == OP_LL);
                if (imemload[31:26] == OP_LL && ATOMIC_EN == 0) w.illegal = 1'b1;
            end
            OP_SW, OP_SC: begin
                w.dWEN    = 1'b1;
                w.ALUsrc  = ALUSRC_IMM;
                w.ExtOp   = 1'b1;
                if (imemload[31:26] == OP_SC) begin
                    // SC writes its success flag back into rt from the memory side
                    w.RegWr    = 1'b1;
                    w.RegDst   = REGDST_RT;
                    w.MemToReg = MEMTOREG_MEM;
                    w.datomic  = 1'b1;
                    if (ATOMIC_EN == 0) w.illegal = 1'b1;
                end
            end
            OP_HALT: w.halt = 1'b1;
            default: w.illegal = 1'b1;
        endcase
        if (w.illegal) begin
            w.RegWr    = 1'b0;
            w.dWEN     = 1'b0;
            w.dREN     = 1'b0;
            w.PCsrc    = 1'b0;
            w.BNE      = 1'b0;
            w.halt     = 1'b0;
            w.datomic  = 1'b0;
            w.is_jump  = 1'b0;
            w.JumpSel  = JUMPSEL_SEQ;
            w.MemToReg = MEMTOREG_ALU;
        end
    end

    assign ctrl = w;

endmodule

// File: rtl/pipelined_decode_stage.sv
// Registered decode stage: decodes accepted words into a small FIFO between fetch and execute.
module pipelined_decode_stage
    import cpu_types_pkg::*;
#(
    parameter int WORD_W     = 32,
    parameter int SKID_DEPTH = 2,
    parameter int ATOMIC_EN  = 1
) (
    input  logic                            CLK,
    input  logic                            nRST,
    input  logic [WORD_W-1:0]               imemload,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic                            flush,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [CTRL_W-1:0]               ctrl,
    output logic                            halt,
    output logic                            jumpFlush,
    output logic [$clog2(SKID_DEPTH+1)-1:0] occupancy
);

    localparam int PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
    localparam int CNT_W = $clog2(SKID_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(SKID_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(SKID_DEPTH - 1);

    ctrl_word_t       mem_q [SKID_DEPTH];
    ctrl_word_t       dec_word;
    ctrl_word_t       head;
    logic [CTRL_W-1:0] dec_bits;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             halt_q, halt_d, halt_pending_q, halt_pending_d;
    logic             jump_flush_q, jump_flush_d;
    logic             pop_req, push, pop;

    ctrl_decoder #(.ATOMIC_EN(ATOMIC_EN)) u_dec (
        .imemload (imemload[31:0]),
        .ctrl     (dec_bits)
    );

    assign dec_word  = dec_bits;
    assign head      = mem_q[rd_ptr_q];
    assign out_valid = (count_q != '0);
    assign ctrl      = out_valid ? head : '0;
    assign halt      = halt_q;
    assign jumpFlush = jump_flush_q;
    assign occupancy = count_q;

    always_comb begin
        pop_req  = out_valid & out_ready;
        // A full buffer still accepts when the head leaves on the same edge
        in_ready = ~halt_pending_q & ~halt_q & ((count_q < DEPTH_C) | pop_req);
        push     = in_valid & in_ready & ~flush;
        pop      = pop_req & ~flush;

        rd_ptr_d       = rd_ptr_q;
        wr_ptr_d       = wr_ptr_q;
        count_d        = count_q;
        halt_d         = halt_q;
        halt_pending_d = halt_pending_q;
        jump_flush_d   = pop & head.is_jump;

        if (flush) begin
            rd_ptr_d       = '0;
            wr_ptr_d       = '0;
            count_d        = '0;
            halt_pending_d = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
                if (dec_word.halt) halt_pending_d = 1'b1;
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
                if (head.halt) begin
                    halt_d         = 1'b1;
                    halt_pending_d = 1'b0;
                end
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rd_ptr_q       <= '0;
            wr_ptr_q       <= '0;
            count_q        <= '0;
            halt_q         <= 1'b0;
            halt_pending_q <= 1'b0;
            jump_flush_q   <= 1'b0;
        end else begin
            rd_ptr_q       <= rd_ptr_d;
            wr_ptr_q       <= wr_ptr_d;
            count_q        <= count_d;
            halt_q         <= halt_d;
            halt_pending_q <= halt_pending_d;
            jump_flush_q   <= jump_flush_d;
        end
    end

    // Entry storage is data only; validity is carried entirely by count_q
    always_ff @(posedge CLK) begin
        if (push) mem_q[wr_ptr_q] <= dec_word;
    end

endmodule
